// File: rtl/maxnet_pkg.sv
// Shared definitions for the maxnet feeder: default sizes, feeder state
// encoding and a few single-precision constants used by benches.
package maxnet_pkg;

  localparam int MN_DATA_W = 32;
  localparam int MN_N_IN   = 4;

  // Binary-encoded feeder states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } feeder_state_e;

  // IEEE-754 single-precision constants.
  localparam logic [31:0] FP_ZERO           = 32'h0000_0000;
  localparam logic [31:0] FP_TENTH          = 32'h3DCC_CCCD;
  localparam logic [31:0] FP_QUARTER        = 32'h3E80_0000;
  localparam logic [31:0] FP_HALF           = 32'h3F00_0000;
  localparam logic [31:0] FP_THREE_QUARTERS = 32'h3F40_0000;
  localparam logic [31:0] FP_ONE            = 32'h3F80_0000;

endpackage

// File: rtl/maxnet_feeder.sv
// Wrapper stage around the maxnet core. Gathers N_IN activations from a
// valid/ready stream into a parallel vector, fires the core's one-shot start,
// captures the result on a rising done and offers it on a valid/ready output.
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int DATA_W = MN_DATA_W,
  parameter int N_IN   = MN_N_IN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   mn_start,
  output logic [N_IN*DATA_W-1:0] mn_data,
  input  logic                   mn_done,
  input  logic [DATA_W-1:0]      mn_result,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int               CNT_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  feeder_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q [N_IN];
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              done_q;
  logic              in_fire;
  logic              done_rise;

  // A word is taken only while LOAD raises in_ready.
  assign in_fire = in_valid && in_ready;

  // A done level carried over from an earlier run must not complete this one,
  // so completion is the rising edge of mn_done only.
  assign done_rise = mn_done && !done_q;

  // Next-state, counter and result-capture decisions plus state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left one
    // unassigned would make synthesis infer a latch to hold its old value.
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    mn_start   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Leaving IDLE one edge after reset keeps in_ready low through reset.
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        mn_start = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          out_data_d = mn_result;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, word counter, done history and captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so the order of these lines does not matter.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= mn_done;
      out_data_q <= out_data_d;
    end
  end

  // Activation buffer: one word written per accepted transfer, read in parallel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this small array is reset on purpose because mn_data exposes it
      // directly and must read zero after reset; larger storage whose contents
      // are never visible before being written would normally stay unreset.
      for (int k = 0; k < N_IN; k++) begin
        buf_q[k] <= '0;
      end
    end else if (in_fire) begin
      buf_q[cnt_q] <= in_data;
    end
  end

  // Word k of the vector sits at bits [k*DATA_W +: DATA_W]; word 0 came first.
  for (genvar k = 0; k < N_IN; k++) begin : g_pack
    assign mn_data[k*DATA_W +: DATA_W] = buf_q[k];
  end

  assign out_data = out_data_q;

endmodule
